// File: rtl/impulse_pulse_gen.sv
// Programmable burst pulse generator driving the impulse counting path.
// Optional continuous mode (pulse_count=0) when IMPULSE_PULSEGEN_CONT_EN is defined.
module impulse_pulse_gen #(
    parameter int CNT_W = 12,
    parameter int TW    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_count,
    input  logic [TW-1:0]    high_cycles,
    input  logic [TW-1:0]    low_cycles,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_HIGH = 4'b0010,
        S_LOW  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [TW-1:0]    hi_q;
    logic [TW-1:0]    lo_q;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    hi_in;
    logic [TW-1:0]    lo_in;
    logic             timer_zero;
    logic             last_pulse;
    logic             empty_req;
    logic             accept;

    assign hi_in      = (high_cycles == '0) ? TW'(1) : high_cycles;
    assign lo_in      = (low_cycles == '0) ? TW'(1) : low_cycles;
    assign timer_zero = (timer == '0);
    assign accept     = (state == S_IDLE) && start && !abort;

`ifdef IMPULSE_PULSEGEN_CONT_EN
    // A zero count runs forever, so it never reaches the last pulse.
    assign empty_req  = 1'b0;
    assign last_pulse = (cnt_q != '0) && (sent_count == cnt_q);
`else
    assign empty_req  = (pulse_count == '0);
    assign last_pulse = (sent_count == cnt_q);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = empty_req ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (timer_zero) begin
                    state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (timer_zero) begin
                    state_nxt = last_pulse ? S_DONE : S_HIGH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            timer      <= '0;
            sent_count <= '0;
        end else if (accept) begin
            cnt_q      <= pulse_count;
            hi_q       <= hi_in;
            lo_q       <= lo_in;
            timer      <= hi_in - TW'(1);
            sent_count <= '0;
        end else if (state == S_HIGH && !abort) begin
            if (timer_zero) begin
                timer <= lo_q - TW'(1);
                // Saturation only matters in continuous mode.
                if (sent_count != CNT_MAX) begin
                    sent_count <= sent_count + CNT_W'(1);
                end
            end else begin
                timer <= timer - TW'(1);
            end
        end else if (state == S_LOW && !abort) begin
            if (timer_zero) begin
                timer <= hi_q - TW'(1);
            end else begin
                timer <= timer - TW'(1);
            end
        end
    end

    // Decoded straight from one-hot state flops: no input-to-output path.
    always_comb begin
        pulse_out = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_HIGH: begin
                pulse_out = 1'b1;
                busy      = 1'b1;
            end
            S_LOW:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_impulse_pulse_gen.sv
// Scoreboard bench for impulse_pulse_gen: per-cycle expected outputs
// are queued when a burst is started and compared as cycles elapse.
module tb_impulse_pulse_gen;

    localparam int CNT_W = 12;
    localparam int TW    = 16;

    typedef struct packed {
        logic             po;
        logic             bz;
        logic             dn;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] pulse_count;
    logic [TW-1:0]    high_cycles;
    logic [TW-1:0]    low_cycles;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_count;

    exp_t q[$];
    int   n_total;
    int   n_pass;
    int   n_rise;

    impulse_pulse_gen #(.CNT_W(CNT_W), .TW(TW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pulse_count (pulse_count),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .sent_count  (sent_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] observed=%0d expected=%0d",
                    tag, idx, obs, exp);
    endtask

    // Reference burst: H high cycles then L low cycles per pulse, then done.
    task automatic push_burst(input int n, input int h, input int l);
        int hh;
        int ll;
        exp_t e;
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hh; j++) begin
                e = '{po: 1'b1, bz: 1'b1, dn: 1'b0, sc: CNT_W'(i)};
                q.push_back(e);
            end
            for (int j = 0; j < ll; j++) begin
                e = '{po: 1'b0, bz: 1'b1, dn: 1'b0, sc: CNT_W'(i + 1)};
                q.push_back(e);
            end
        end
        e = '{po: 1'b0, bz: 1'b0, dn: 1'b1, sc: CNT_W'(n)};
        q.push_back(e);
        e.dn = 1'b0;
        q.push_back(e);
    endtask

    task automatic launch(input int n, input int h, input int l);
        pulse_count = CNT_W'(n);
        high_cycles = TW'(h);
        low_cycles  = TW'(l);
        start       = 1'b1;
    endtask

    task automatic drain(input int poke_idx, input int abort_idx,
                         input int limit);
        exp_t e;
        logic prev;
        int   k;
        prev = pulse_out;
        k    = 0;
        while (q.size() > 0 && k < limit) begin
            @(posedge clock);
            #1;
            e = q.pop_front();
            chk("pulse_out", k, 32'(pulse_out), 32'(e.po));
            chk("busy", k, 32'(busy), 32'(e.bz));
            chk("done", k, 32'(done), 32'(e.dn));
            chk("sent_count", k, 32'(sent_count), 32'(e.sc));
            if (pulse_out && !prev) n_rise++;
            prev  = pulse_out;
            start = (k == poke_idx);
            abort = (k == abort_idx);
            if (k == poke_idx) begin
                pulse_count = CNT_W'(1);
                high_cycles = TW'(9);
                low_cycles  = TW'(7);
            end
            k++;
        end
        start = 1'b0;
        abort = 1'b0;
        q.delete();
    endtask

    initial begin
        exp_t e;
        n_total     = 0;
        n_pass      = 0;
        n_rise      = 0;
        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        pulse_count = '0;
        high_cycles = '0;
        low_cycles  = '0;
        #12;
        chk("rst_pulse_out", 0, 32'(pulse_out), 0);
        chk("rst_busy", 0, 32'(busy), 0);
        chk("rst_done", 0, 32'(done), 0);
        chk("rst_sent", 0, 32'(sent_count), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        launch(3, 2, 3);
        push_burst(3, 2, 3);
        drain(-1, -1, 1000);

`ifndef IMPULSE_PULSEGEN_CONT_EN
        launch(0, 2, 3);
        push_burst(0, 2, 3);
        drain(-1, -1, 1000);
`endif

        launch(5, 0, 0);
        push_burst(5, 0, 0);
        drain(-1, -1, 1000);

        launch(4, 4, 4);
        push_burst(4, 4, 4);
        drain(5, -1, 1000);

        // start together with abort in IDLE must be ignored
        start = 1'b1;
        abort = 1'b1;
        e = '{po: 1'b0, bz: 1'b0, dn: 1'b0, sc: CNT_W'(4)};
        q.push_back(e);
        q.push_back(e);
        drain(-1, -1, 1000);

        launch(10, 3, 2);
        push_burst(10, 3, 2);
        while (q.size() > 11) void'(q.pop_back());
        e = '{po: 1'b0, bz: 1'b0, dn: 1'b0, sc: CNT_W'(2)};
        q.push_back(e);
        q.push_back(e);
        drain(-1, 10, 1000);

        launch(100, 1, 1);
        push_burst(100, 1, 1);
        drain(-1, -1, 37);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pulse_out", 0, 32'(pulse_out), 0);
        chk("arst_busy", 0, 32'(busy), 0);
        chk("arst_done", 0, 32'(done), 0);
        chk("arst_sent", 0, 32'(sent_count), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        n_rise = 0;
        launch(100, 1, 1);
        push_burst(100, 1, 1);
        drain(-1, -1, 1000);
        chk("rise_count", 0, 32'(n_rise), 100);

        launch(4095, 1, 1);
        push_burst(4095, 1, 1);
        drain(-1, -1, 10000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
